// File: rtl/cofre_pkg.sv
// Shared definitions for the safe controller: state encoding, widths and
// the near-miss threshold used when a wrong attempt is graded.
package cofre_pkg;

    localparam int unsigned LARG_SENHA   = 4;
    localparam int unsigned LARG_ERROS   = 2;
    localparam int unsigned LARG_BLOQ    = 8;
    localparam int unsigned PERTO_LIMIAR = 3;

    typedef enum logic [1:0] {
        TRAVADO   = 2'd0,
        ABERTO    = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

endpackage

// File: rtl/controle_cofre_if.sv
// User-facing bundle of the safe: attempt/command inputs and status LEDs.
interface controle_cofre_if;
    import cofre_pkg::*;

    logic [LARG_SENHA-1:0] tentativa;
    logic                  confirma;
    logic                  grava;
    logic                  fecha;
    logic                  led0;
    logic                  led1;
    logic                  led2;
    logic                  bloqueado;
    logic [LARG_ERROS-1:0] tentativas_rest;
    logic [LARG_SENHA-1:0] diferenca;

    modport master (
        output tentativa, confirma, grava, fecha,
        input  led0, led1, led2, bloqueado, tentativas_rest, diferenca
    );

    modport slave (
        input  tentativa, confirma, grava, fecha,
        output led0, led1, led2, bloqueado, tentativas_rest, diferenca
    );

endinterface

// File: rtl/avaliador_senha.sv
// Combinational grading of an attempt: absolute distance to the password,
// exact-match flag and near-miss flag.
module avaliador_senha
    import cofre_pkg::*;
(
    input  logic [LARG_SENHA-1:0] senha,
    input  logic [LARG_SENHA-1:0] tentativa,
    output logic [LARG_SENHA-1:0] diferenca,
    output logic                  igual,
    output logic                  perto
);

    logic [LARG_SENHA:0] sub_c;

    // Extra bit catches the borrow so the distance never wraps modulo 16.
    always_comb begin
        sub_c = {1'b0, senha} - {1'b0, tentativa};
        if (sub_c[LARG_SENHA]) begin
            diferenca = tentativa - senha;
        end else begin
            diferenca = sub_c[LARG_SENHA-1:0];
        end
        igual = (diferenca == '0);
        perto = !igual && (diferenca <= LARG_SENHA'(PERTO_LIMIAR));
    end

endmodule

// File: rtl/controle_cofre.sv
// Safe controller: password check with near/far hints, wrong-attempt
// counting, timed lockout and password recording while open.
module controle_cofre
    import cofre_pkg::*;
#(
    parameter logic [3:0]  SENHA_PADRAO   = 4'd0,
    parameter int unsigned MAX_TENTATIVAS = 3,
    parameter int unsigned TEMPO_BLOQUEIO = 8
) (
    input  logic              clk,
    input  logic              rst,
    controle_cofre_if.slave   bus
);

    localparam logic [LARG_ERROS-1:0] ERROS_MAX = LARG_ERROS'(MAX_TENTATIVAS);
    localparam logic [LARG_BLOQ-1:0]  BLOQ_INI  = LARG_BLOQ'(TEMPO_BLOQUEIO);

    estado_t               estado, estado_n;
    logic [LARG_SENHA-1:0] senha, senha_n;
    logic [LARG_ERROS-1:0] erros, erros_n;
    logic [LARG_BLOQ-1:0]  cont, cont_n;
    logic                  led0, led0_n;
    logic                  led1, led1_n;
    logic                  led2, led2_n;
    logic                  bloq, bloq_n;
    logic [LARG_ERROS-1:0] rest, rest_n;
    logic [LARG_SENHA-1:0] dif, dif_n;

    logic [LARG_SENHA-1:0] dif_c;
    logic                  igual_c;
    logic                  perto_c;
    logic [LARG_ERROS-1:0] erros_inc_c;

    avaliador_senha u_avaliador (
        .senha     (senha),
        .tentativa (bus.tentativa),
        .diferenca (dif_c),
        .igual     (igual_c),
        .perto     (perto_c)
    );

    assign erros_inc_c = erros + LARG_ERROS'(1);

    // State and every output-driving register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= TRAVADO;
            senha  <= SENHA_PADRAO;
            erros  <= '0;
            cont   <= '0;
            led0   <= 1'b0;
            led1   <= 1'b0;
            led2   <= 1'b0;
            bloq   <= 1'b0;
            rest   <= ERROS_MAX;
            dif    <= '0;
        end else begin
            estado <= estado_n;
            senha  <= senha_n;
            erros  <= erros_n;
            cont   <= cont_n;
            led0   <= led0_n;
            led1   <= led1_n;
            led2   <= led2_n;
            bloq   <= bloq_n;
            rest   <= rest_n;
            dif    <= dif_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        estado_n = estado;
        senha_n  = senha;
        erros_n  = erros;
        cont_n   = cont;
        led0_n   = led0;
        led1_n   = led1;
        led2_n   = led2;
        bloq_n   = bloq;
        rest_n   = rest;
        dif_n    = dif;

        unique case (estado)
            TRAVADO: begin
                if (bus.confirma) begin
                    dif_n = dif_c;
                    if (igual_c) begin
                        estado_n = ABERTO;
                        led0_n   = 1'b1;
                        led1_n   = 1'b0;
                        led2_n   = 1'b0;
                        erros_n  = '0;
                        rest_n   = ERROS_MAX;
                    end else begin
                        led1_n  = perto_c;
                        led2_n  = !perto_c;
                        erros_n = erros_inc_c;
                        rest_n  = ERROS_MAX - erros_inc_c;
                        if (erros_inc_c == ERROS_MAX) begin
                            estado_n = BLOQUEADO;
                            bloq_n   = 1'b1;
                            cont_n   = BLOQ_INI;
                        end
                    end
                end
            end

            ABERTO: begin
                if (bus.grava) begin
                    senha_n = bus.tentativa;
                end
                if (bus.fecha) begin
                    estado_n = TRAVADO;
                    led0_n   = 1'b0;
                    led1_n   = 1'b0;
                    led2_n   = 1'b0;
                    dif_n    = '0;
                end
            end

            BLOQUEADO: begin
                // Leaving on the edge where the count hits zero keeps the
                // lockout exactly BLOQ_INI cycles long.
                if (cont <= LARG_BLOQ'(1)) begin
                    estado_n = TRAVADO;
                    cont_n   = '0;
                    bloq_n   = 1'b0;
                    erros_n  = '0;
                    rest_n   = ERROS_MAX;
                    led1_n   = 1'b0;
                    led2_n   = 1'b0;
                    dif_n    = '0;
                end else begin
                    cont_n = cont - LARG_BLOQ'(1);
                end
            end

            default: begin
                estado_n = TRAVADO;
            end
        endcase
    end

    assign bus.led0            = led0;
    assign bus.led1            = led1;
    assign bus.led2            = led2;
    assign bus.bloqueado       = bloq;
    assign bus.tentativas_rest = rest;
    assign bus.diferenca       = dif;

endmodule

// File: tb/tb_controle_cofre.sv
// Directed bench for controle_cofre with SENHA_PADRAO=5 and default limits.
module tb_controle_cofre;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    controle_cofre_if bus ();

    controle_cofre #(
        .SENHA_PADRAO   (4'd5),
        .MAX_TENTATIVAS (3),
        .TEMPO_BLOQUEIO (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {led0, led1, led2, bloqueado, tentativas_rest, diferenca}
    function automatic logic [9:0] outs();
        return {bus.led0, bus.led1, bus.led2, bus.bloqueado,
                bus.tentativas_rest, bus.diferenca};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic attempt(input logic [3:0] v);
        bus.tentativa = v;
        bus.confirma  = 1'b1;
        step();
        bus.confirma  = 1'b0;
    endtask

    task automatic close_safe();
        bus.fecha = 1'b1;
        step();
        bus.fecha = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp = {4'b0000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL reset got=%b exp=%b", outs(), exp);
        end
    endtask

    task automatic test_open();
        logic [9:0] exp;
        attempt(4'd5);
        exp = {4'b1000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL open_default got=%b exp=%b", outs(), exp);
        end
        bus.tentativa = 4'd0;
        bus.confirma  = 1'b1;
        step();
        bus.confirma  = 1'b0;
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL confirma_while_open got=%b exp=%b", outs(), exp);
        end
        close_safe();
        exp = {4'b0000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL fecha got=%b exp=%b", outs(), exp);
        end
    endtask

    task automatic test_near_far();
        logic [9:0] exp;
        attempt(4'd7);
        exp = {4'b0100, 2'd2, 4'd2};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL near_7 got=%b exp=%b", outs(), exp);
        end
        attempt(4'd1);
        exp = {4'b0010, 2'd1, 4'd4};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL far_1 got=%b exp=%b", outs(), exp);
        end
        attempt(4'd5);
        exp = {4'b1000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL open_after_errors got=%b exp=%b", outs(), exp);
        end
        close_safe();
    endtask

    task automatic test_lockout();
        logic [9:0] exp;
        attempt(4'd0);
        attempt(4'd0);
        exp = {4'b0010, 2'd1, 4'd5};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL second_wrong got=%b exp=%b", outs(), exp);
        end
        attempt(4'd0);
        exp = {4'b0011, 2'd0, 4'd5};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL lockout_enter got=%b exp=%b", outs(), exp);
        end
        // lockout cycle 1: a correct attempt must be ignored
        bus.grava = 1'b1;
        bus.fecha = 1'b1;
        attempt(4'd5);
        bus.grava = 1'b0;
        bus.fecha = 1'b0;
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL lockout_ignores got=%b exp=%b", outs(), exp);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL lockout_cycle7 got=%b exp=%b", outs(), exp);
        end
        step();
        exp = {4'b0000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL lockout_expiry got=%b exp=%b", outs(), exp);
        end
        attempt(4'd5);
        exp = {4'b1000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL open_after_lockout got=%b exp=%b", outs(), exp);
        end
    endtask

    task automatic test_grava_fecha();
        logic [9:0] exp;
        bus.tentativa = 4'd9;
        bus.grava     = 1'b1;
        bus.fecha     = 1'b1;
        step();
        bus.grava     = 1'b0;
        bus.fecha     = 1'b0;
        exp = {4'b0000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL grava_fecha got=%b exp=%b", outs(), exp);
        end
        attempt(4'd5);
        exp = {4'b0010, 2'd2, 4'd4};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL old_pwd_rejected got=%b exp=%b", outs(), exp);
        end
        attempt(4'd9);
        exp = {4'b1000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL new_pwd_opens got=%b exp=%b", outs(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        close_safe();
        bus.tentativa = 4'd3;
        bus.grava     = 1'b1;
        step();
        bus.grava     = 1'b0;
        exp = {4'b0000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL grava_locked got=%b exp=%b", outs(), exp);
        end
        bus.confirma = 1'b1;
        step();
        exp = {4'b0010, 2'd2, 4'd6};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL held_1 got=%b exp=%b", outs(), exp);
        end
        step();
        bus.confirma = 1'b0;
        exp = {4'b0010, 2'd1, 4'd6};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL held_2 got=%b exp=%b", outs(), exp);
        end
        attempt(4'd9);
        exp = {4'b1000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL open_9 got=%b exp=%b", outs(), exp);
        end
    endtask

    task automatic test_reset_lockout();
        logic [9:0] exp;
        close_safe();
        attempt(4'd0);
        attempt(4'd0);
        attempt(4'd0);
        exp = {4'b0011, 2'd0, 4'd9};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL lockout_9 got=%b exp=%b", outs(), exp);
        end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp = {4'b0000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL reset_mid_lockout got=%b exp=%b", outs(), exp);
        end
        attempt(4'd5);
        exp = {4'b1000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL default_pwd_restored got=%b exp=%b", outs(), exp);
        end
    endtask

    task automatic test_boundaries();
        logic [9:0] exp;
        bus.tentativa = 4'd1;
        bus.grava     = 1'b1;
        step();
        bus.grava     = 1'b0;
        close_safe();
        attempt(4'd15);
        exp = {4'b0010, 2'd2, 4'd14};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL dist_1_15 got=%b exp=%b", outs(), exp);
        end
        attempt(4'd1);
        bus.tentativa = 4'd0;
        bus.grava     = 1'b1;
        bus.fecha     = 1'b1;
        step();
        bus.grava     = 1'b0;
        bus.fecha     = 1'b0;
        attempt(4'd3);
        exp = {4'b0100, 2'd2, 4'd3};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL dist_0_3 got=%b exp=%b", outs(), exp);
        end
        attempt(4'd4);
        exp = {4'b0010, 2'd1, 4'd4};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL dist_0_4 got=%b exp=%b", outs(), exp);
        end
        attempt(4'd0);
        exp = {4'b1000, 2'd3, 4'd0};
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL open_0 got=%b exp=%b", outs(), exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.tentativa = 4'd0;
        bus.confirma  = 1'b0;
        bus.grava     = 1'b0;
        bus.fecha     = 1'b0;
        test_reset();
        test_open();
        test_near_far();
        test_lockout();
        test_grava_fecha();
        test_back_to_back();
        test_reset_lockout();
        test_boundaries();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
